// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: datapath width, PC increment, timeout depth and FSM encoding.
package fetch_unit_pkg;

    localparam int DEF_WORD_W   = 16;
    localparam int DEF_PC_STEP  = 2;
    localparam int DEF_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_WAIT  = 2'd2,
        FS_WRITE = 2'd3
    } fetch_state_t;

    // The wait counter only has to reach MAX_WAIT-1 before the timeout fires.
    function automatic int wait_cnt_width(input int max_wait);
        return (max_wait < 2) ? 1 : $clog2(max_wait);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: reads one instruction at pc_in, loads the IR and
// hands PC+PC_STEP to the PC module with a single-cycle PCWrite.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int WORD_W   = DEF_WORD_W,
    parameter int PC_STEP  = DEF_PC_STEP,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [WORD_W-1:0] pc_in,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [WORD_W-1:0] ir_out,
    output logic [WORD_W-1:0] pc_next,
    output logic              PCWrite,
    output logic              fetch_done,
    output logic              fetch_error,
    output logic              busy
);

    localparam int              CNT_W     = wait_cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    fetch_state_t     state;
    logic [CNT_W-1:0] wait_cnt;

    // NOTE: every register here, outputs included, is assigned with <= so all
    // of them see the same pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FS_IDLE;
            wait_cnt    <= '0;
            mem_addr    <= '0;
            mem_read    <= 1'b0;
            ir_out      <= '0;
            pc_next     <= '0;
            PCWrite     <= 1'b0;
            fetch_done  <= 1'b0;
            fetch_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            PCWrite    <= 1'b0;
            fetch_done <= 1'b0;

            case (state)
                FS_IDLE: begin
                    if (fetch_start) begin
                        mem_addr    <= pc_in;
                        fetch_error <= 1'b0;
                        wait_cnt    <= '0;
                        mem_read    <= 1'b1;
                        busy        <= 1'b1;
                        state       <= FS_REQ;
                    end
                end

                FS_REQ, FS_WAIT: begin
                    // Priority: flush beats a ready response and beats the timeout.
                    if (flush) begin
                        mem_read <= 1'b0;
                        busy     <= 1'b0;
                        state    <= FS_IDLE;
                    end else if (mem_ready) begin
                        ir_out     <= mem_rdata;
                        pc_next    <= mem_addr + WORD_W'(PC_STEP);
                        mem_read   <= 1'b0;
                        PCWrite    <= 1'b1;
                        fetch_done <= 1'b1;
                        state      <= FS_WRITE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fetch_error <= 1'b1;
                        mem_read    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= FS_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        state    <= FS_WAIT;
                    end
                end

                FS_WRITE: begin
                    busy  <= 1'b0;
                    state <= FS_IDLE;
                end

                default: state <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed fetches feed an expectation queue that a
// negedge monitor drains whenever PCWrite is presented.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        fetch_start;
    logic        flush;
    logic [15:0] pc_in;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir_out;
    logic [15:0] pc_next;
    logic        PCWrite;
    logic        fetch_done;
    logic        fetch_error;
    logic        busy;

    logic [15:0] pc_drv;
    logic [15:0] pc_reg;
    logic        use_pc_model;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pcn;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_start (fetch_start),
        .flush       (flush),
        .pc_in       (pc_in),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .ir_out      (ir_out),
        .pc_next     (pc_next),
        .PCWrite     (PCWrite),
        .fetch_done  (fetch_done),
        .fetch_error (fetch_error),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for the external PC register.
    always @(posedge clock) begin
        if (!use_pc_model) pc_reg <= 16'h0000;
        else if (PCWrite)  pc_reg <= pc_next;
    end

    assign pc_in = use_pc_model ? pc_reg : pc_drv;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (PCWrite || fetch_done)) begin
            check("done_eq_pcwrite", 16'(fetch_done), 16'(PCWrite));
            if (exp_q.size() == 0) begin
                check("unexpected_pcwrite", 16'(PCWrite), 16'h0000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ir_out", ir_out, e.ir);
                check("pc_next", pc_next, e.pcn);
            end
        end
    end

    task automatic do_fetch(input logic [15:0] pc, input logic [15:0] rdata, input int waits,
                            input logic [15:0] exp_ir, input logic [15:0] exp_pcn);
        @(negedge clock);
        pc_drv      = pc;
        fetch_start = 1'b1;
        exp_q.push_back('{ir: exp_ir, pcn: exp_pcn});
        @(negedge clock);
        fetch_start = 1'b0;
        check("error_cleared", 16'(fetch_error), 16'h0000);
        for (int i = 0; i < waits; i++) begin
            check("wait_mem_read", 16'(mem_read), 16'h0001);
            check("wait_mem_addr", mem_addr, pc);
            @(negedge clock);
        end
        check("ready_mem_read", 16'(mem_read), 16'h0001);
        check("ready_mem_addr", mem_addr, pc);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(negedge clock);
        mem_ready = 1'b0;
        mem_rdata = 16'hXXXX;
        check("pcwrite_latency", 16'(PCWrite), 16'h0001);
        check("write_mem_read", 16'(mem_read), 16'h0000);
        @(negedge clock);
        check("pcwrite_one_cycle", 16'(PCWrite), 16'h0000);
        check("idle_busy", 16'(busy), 16'h0000);
    endtask

    initial begin
        reset        = 1'b1;
        fetch_start  = 1'b0;
        flush        = 1'b0;
        pc_drv       = 16'h0000;
        mem_rdata    = 16'h0000;
        mem_ready    = 1'b0;
        use_pc_model = 1'b0;

        // 1: reset
        repeat (2) @(negedge clock);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_read", 16'(mem_read), 16'h0000);
        check("rst_ir_out", ir_out, 16'h0000);
        check("rst_pc_next", pc_next, 16'h0000);
        check("rst_pcwrite", 16'(PCWrite), 16'h0000);
        check("rst_fetch_done", 16'(fetch_done), 16'h0000);
        check("rst_fetch_error", 16'(fetch_error), 16'h0000);
        check("rst_busy", 16'(busy), 16'h0000);
        reset = 1'b0;

        // 2: zero-wait fetch
        do_fetch(16'h0010, 16'hA5C3, 0, 16'hA5C3, 16'h0012);

        // 3: three-wait fetch with address wrap
        do_fetch(16'hFFFE, 16'h1234, 3, 16'h1234, 16'h0000);

        // 4: timeout after MAX_WAIT=8 read cycles
        @(negedge clock);
        pc_drv      = 16'h0100;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("to_mem_read", 16'(mem_read), 16'h0001);
            @(negedge clock);
        end
        check("to_fetch_error", 16'(fetch_error), 16'h0001);
        check("to_mem_read_off", 16'(mem_read), 16'h0000);
        check("to_busy", 16'(busy), 16'h0000);
        check("to_ir_kept", ir_out, 16'h1234);
        check("to_pcn_kept", pc_next, 16'h0000);
        do_fetch(16'h0100, 16'h4321, 0, 16'h4321, 16'h0102);

        // 5: flush and ready together; fetch_start in WAIT ignored
        @(negedge clock);
        pc_drv      = 16'h0200;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        @(negedge clock);
        fetch_start = 1'b1;
        pc_drv      = 16'h0300;
        @(negedge clock);
        fetch_start = 1'b0;
        check("wait_addr_stable", mem_addr, 16'h0200);
        flush     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        @(negedge clock);
        flush     = 1'b0;
        mem_ready = 1'b0;
        check("fl_busy", 16'(busy), 16'h0000);
        check("fl_mem_read", 16'(mem_read), 16'h0000);
        check("fl_ir_kept", ir_out, 16'h4321);
        check("fl_pcn_kept", pc_next, 16'h0102);
        repeat (2) @(negedge clock);
        check("fl_start_not_queued", 16'(busy), 16'h0000);

        // flush coinciding with the timeout cycle
        pc_drv      = 16'h0400;
        fetch_start = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        repeat (7) @(negedge clock);
        check("flto_mem_read", 16'(mem_read), 16'h0001);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flto_no_error", 16'(fetch_error), 16'h0000);
        check("flto_busy", 16'(busy), 16'h0000);

        // 6: PC module attached, back-to-back fetches from 0x0000
        use_pc_model = 1'b1;
        @(negedge clock);
        check("pc_start", pc_reg, 16'h0000);
        do_fetch(16'h0000, 16'h1111, 0, 16'h1111, 16'h0002);
        check("pc_1", pc_reg, 16'h0002);
        do_fetch(16'h0002, 16'h2222, 1, 16'h2222, 16'h0004);
        check("pc_2", pc_reg, 16'h0004);
        repeat (3) @(negedge clock);
        check("pc_hold", pc_reg, 16'h0004);
        do_fetch(16'h0004, 16'h3333, 0, 16'h3333, 16'h0006);
        check("pc_3", pc_reg, 16'h0006);

        // reset mid-fetch
        use_pc_model = 1'b0;
        pc_drv       = 16'h0500;
        fetch_start  = 1'b1;
        @(negedge clock);
        fetch_start = 1'b0;
        @(negedge clock);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        @(negedge clock);
        mem_ready = 1'b0;
        check("mrst_busy", 16'(busy), 16'h0000);
        check("mrst_mem_read", 16'(mem_read), 16'h0000);
        check("mrst_ir_out", ir_out, 16'h0000);
        check("mrst_pc_next", pc_next, 16'h0000);
        reset = 1'b0;
        @(negedge clock);

        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
